// File: rtl/stack_ctrl.sv
// stack_ctrl: parametrised LIFO stack with registered top/peek, replace-top, sticky errors
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   push_i       write data_i onto the stack
//   pop_i        remove top entry into data_o
//   data_i       push data
//   clear_err_i  synchronous clear of overflow/underflow
//   data_o       registered popped word
//   pop_valid_o  1-cycle pulse, data_o updated
//   top_o        registered top-of-stack (0 when empty)
//   count_o      number of entries, 0..DEPTH
//   empty_o      count == 0
//   full_o       count == DEPTH
//   overflow_o   sticky: push rejected because full
//   underflow_o  sticky: pop rejected because empty
module stack_ctrl #(
   parameter int STACK_WIDTH = 18,
   parameter int STACK_SIZE  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [STACK_WIDTH-1:0] data_i,
   input  logic                   clear_err_i,
   output logic [STACK_WIDTH-1:0] data_o,
   output logic                   pop_valid_o,
   output logic [STACK_WIDTH-1:0] top_o,
   output logic [STACK_SIZE:0]    count_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   overflow_o,
   output logic                   underflow_o
);
   localparam logic [STACK_SIZE:0] DEPTH = {1'b1, {STACK_SIZE{1'b0}}};
   logic [STACK_WIDTH-1:0] mem [0:(1<<STACK_SIZE)-1];
   logic [STACK_SIZE:0] count_q, count_d;
   logic [STACK_WIDTH-1:0] top_q, top_d, data_q, data_d;
   logic pv_d, pv_q, ovf_q, ovf_d, unf_q, unf_d;
   logic do_push, do_pop, rep, byp, we;
   logic [STACK_SIZE-1:0] waddr, below;
   assign empty_o = count_q == '0;
   assign full_o  = count_q == DEPTH;
   always_comb begin
      do_push = push_i & ~pop_i & ~full_o;
      do_pop  = pop_i & ~push_i & ~empty_o;
      rep     = push_i & pop_i & ~empty_o;
      byp     = push_i & pop_i & empty_o;
      we      = do_push | rep;
      // replace overwrites the current top slot; plain push writes the next free one
      waddr   = do_push ? count_q[STACK_SIZE-1:0] : count_q[STACK_SIZE-1:0] - 1'b1;
      // entry under the top; low bits wrap correctly when count == DEPTH
      below   = count_q[STACK_SIZE-1:0] - 2'd2;
      count_d = do_push ? count_q + 1'b1 : do_pop ? count_q - 1'b1 : count_q;
      top_d   = we ? data_i : do_pop ? (|count_q[STACK_SIZE:1] ? mem[below] : '0) : top_q;
      pv_d    = do_pop | rep | byp;
      data_d  = byp ? data_i : pv_d ? top_q : data_q;
      // a new error in the same cycle as clear_err wins
      ovf_d   = (push_i & ~pop_i & full_o) | (ovf_q & ~clear_err_i);
      unf_d   = (pop_i & ~push_i & empty_o) | (unf_q & ~clear_err_i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         top_q   <= '0;
         data_q  <= '0;
         pv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         top_q   <= top_d;
         data_q  <= data_d;
         pv_q    <= pv_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end
   // storage is not reset; the write is gated so a reset cycle aborts the op
   always_ff @(posedge clk) begin
      if (rst_n && we) mem[waddr] <= data_i;
   end
   assign data_o      = data_q;
   assign pop_valid_o = pv_q;
   assign top_o       = top_q;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed self-checking bench for stack_ctrl
module tb_stack_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic push = 1'b0, pop = 1'b0, clr = 1'b0;
   logic [17:0] din = '0;
   logic [17:0] dout, top;
   logic pv, empty, full, ovf, unf;
   logic [4:0] count;
   int total = 0, bad = 0;

   stack_ctrl #(.STACK_WIDTH(18), .STACK_SIZE(4)) dut (
      .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .data_i(din),
      .clear_err_i(clr), .data_o(dout), .pop_valid_o(pv), .top_o(top),
      .count_o(count), .empty_o(empty), .full_o(full), .overflow_o(ovf),
      .underflow_o(unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic ps, input logic pp, input logic [17:0] d, input logic cl);
      push = ps;
      pop  = pp;
      din  = d;
      clr  = cl;
      @(posedge clk);
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
      clr  = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_top", top, 0);
      chk("rst_dout", dout, 0);
      chk("rst_pv", pv, 0);
      chk("rst_flags", {ovf, unf}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // 1: basic push/pop
      cyc(1, 0, 18'h00A, 0);
      cyc(1, 0, 18'h00B, 0);
      cyc(1, 0, 18'h00C, 0);
      chk("t1_count", count, 3);
      chk("t1_top", top, 18'h00C);
      cyc(0, 1, 0, 0);
      chk("t1_pop_dout", dout, 18'h00C);
      chk("t1_pop_pv", pv, 1);
      chk("t1_pop_count", count, 2);
      chk("t1_pop_top", top, 18'h00B);
      cyc(0, 0, 0, 0);
      chk("t1_pv_drop", pv, 0);
      chk("t1_dout_hold", dout, 18'h00C);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("t1_drain_dout", dout, 18'h00A);
      chk("t1_drain_empty", empty, 1);
      chk("t1_drain_top", top, 0);
      // 2: fill and overflow
      for (int i = 1; i <= 16; i++) cyc(1, 0, 18'(i), 0);
      chk("t2_full", full, 1);
      chk("t2_count", count, 16);
      cyc(1, 0, 18'h3FFFF, 0);
      chk("t2_ovf", ovf, 1);
      chk("t2_ovf_count", count, 16);
      chk("t2_ovf_top", top, 16);
      cyc(1, 0, 18'h3FFFF, 1);
      chk("t2_ovf_set_wins", ovf, 1);
      cyc(0, 0, 0, 1);
      chk("t2_ovf_clear", ovf, 0);
      cyc(0, 1, 0, 0);
      chk("t2_pop_dout", dout, 16);
      chk("t2_pop_count", count, 15);
      chk("t2_pop_top", top, 15);
      chk("t2_pop_full", full, 0);
      // 5: replace on full stack
      cyc(1, 0, 18'h020, 0);
      chk("t5_refull", full, 1);
      cyc(1, 1, 18'h111, 0);
      chk("t5_rep_dout", dout, 18'h020);
      chk("t5_rep_pv", pv, 1);
      chk("t5_rep_top", top, 18'h111);
      chk("t5_rep_count", count, 16);
      chk("t5_rep_ovf", ovf, 0);
      cyc(0, 1, 0, 0);
      chk("t5_pop_dout", dout, 18'h111);
      chk("t5_pop_top", top, 15);
      // 6: async reset mid-cycle at count 5
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
      chk("t6_count5", count, 5);
      chk("t6_top5", top, 5);
      chk("t6_dout6", dout, 6);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_count", count, 0);
      chk("t6_async_top", top, 0);
      chk("t6_async_dout", dout, 0);
      chk("t6_async_empty", empty, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1, 0, 0);
      chk("t6_unf", unf, 1);
      chk("t6_unf_pv", pv, 0);
      chk("t6_unf_count", count, 0);
      cyc(0, 0, 0, 1);
      chk("t6_unf_clear", unf, 0);
      // 4: bypass on empty
      cyc(1, 1, 18'h0AA, 0);
      chk("t4_byp_dout", dout, 18'h0AA);
      chk("t4_byp_pv", pv, 1);
      chk("t4_byp_count", count, 0);
      chk("t4_byp_empty", empty, 1);
      chk("t4_byp_top", top, 0);
      chk("t4_byp_flags", {ovf, unf}, 0);
      // 3: underflow holds data_out, clear, set wins over clear
      cyc(0, 1, 0, 0);
      chk("t3_unf", unf, 1);
      chk("t3_unf_pv", pv, 0);
      chk("t3_unf_dout", dout, 18'h0AA);
      chk("t3_unf_count", count, 0);
      cyc(0, 0, 0, 1);
      chk("t3_clear", unf, 0);
      cyc(0, 1, 0, 1);
      chk("t3_set_wins", unf, 1);
      // 4: replace at count 2
      cyc(1, 0, 18'h003, 0);
      cyc(1, 0, 18'h005, 0);
      chk("t4_count2", count, 2);
      chk("t4_top5", top, 18'h005);
      cyc(1, 1, 18'h007, 0);
      chk("t4_rep_dout", dout, 18'h005);
      chk("t4_rep_pv", pv, 1);
      chk("t4_rep_count", count, 2);
      chk("t4_rep_top", top, 18'h007);
      cyc(0, 1, 0, 0);
      chk("t4_pop_dout", dout, 18'h007);
      chk("t4_pop_top", top, 18'h003);
      chk("t4_pop_count", count, 1);
      cyc(0, 1, 0, 0);
      chk("t4_last_dout", dout, 18'h003);
      chk("t4_last_top", top, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
